// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - instruction memory read request/acknowledge bus
// Ports (master = fetch unit, slave = instruction memory):
//   mem_req   master->slave  read request, held until acknowledged
//   mem_addr  master->slave  word-aligned byte address of the request
//   mem_ack   slave->master  mem_inst valid for the current request (may be same cycle)
//   mem_inst  slave->master  instruction word returned with mem_ack
interface inst_fetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [INST_W-1:0] mem_inst;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_inst);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_inst);
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch: PC, memory request, fetch FIFO, branch redirect
// Ports:
//   clk_i           clock, all state on rising edge
//   rst_ni          asynchronous active-low reset
//   mem             instruction memory bus (master side)
//   freeze_i        hazard stall, IF/ID does not consume this cycle
//   branch_taken_i  redirect to branch_addr_i, discard buffered and in-flight words
//   branch_addr_i   redirect target, low two bits ignored
//   if_valid_o      if_pc_o/if_inst_o hold a fetched instruction
//   if_pc_o         address of if_inst_o plus 4
//   if_inst_o       fetched instruction at the FIFO head
module inst_fetch_unit #(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter int                FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   inst_fetch_unit_if.master  mem,
   input  logic               freeze_i,
   input  logic               branch_taken_i,
   input  logic [ADDR_W-1:0]  branch_addr_i,
   output logic               if_valid_o,
   output logic [ADDR_W-1:0]  if_pc_o,
   output logic [INST_W-1:0]  if_inst_o
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W = ADDR_W + INST_W;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic {RUN, DISCARD} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic              pend_q;
   logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              req;
   logic              xfer;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] br_target;
   logic              unused_br_lsb;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign br_target     = {branch_addr_i[ADDR_W-1:2], 2'b00};
   assign unused_br_lsb = ^branch_addr_i[1:0];

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      target_d = target_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      push     = 1'b0;
      pop      = 1'b0;
      // A request launches only with FIFO space; once raised, pend_q keeps it up
      // until acknowledged. Gated by reset so the bus is quiet while held in reset.
      req  = rst_ni && ((state_q == DISCARD) || pend_q || (count_q < FULL_CNT));
      xfer = req && mem.mem_ack;

      if (branch_taken_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         if (!req || xfer) begin
            pc_d    = br_target;
            state_d = RUN;
         end else begin
            // Request cannot be withdrawn: finish it at the old address, drop its data.
            target_d = br_target;
            state_d  = DISCARD;
         end
      end else begin
         if (state_q == DISCARD) begin
            if (xfer) begin
               pc_d    = target_q;
               state_d = RUN;
            end
         end else if (xfer) begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(4);
         end
         pop = (count_q != '0) && !freeze_i;
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         target_q <= '0;
         pend_q   <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         pend_q   <= req && !mem.mem_ack;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         // pc_d is pc_q+4 whenever push is set.
         if (push) fifo_q[wr_ptr_q] <= {pc_d, mem.mem_inst};
      end
   end

   assign mem.mem_req             = req;
   assign mem.mem_addr            = pc_q;
   assign if_valid_o              = (count_q != '0);
   assign {if_pc_o, if_inst_o}    = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit
`timescale 1ns/1ps
module tb_inst_fetch_unit;
   localparam int AW    = 32;
   localparam int IW    = 32;
   localparam int DEPTH = 2;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          freeze = 1'b0;
   logic          branch = 1'b0;
   logic [AW-1:0] baddr  = '0;
   logic          if_valid;
   logic [AW-1:0] if_pc;
   logic [IW-1:0] if_inst;

   inst_fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

   inst_fetch_unit #(
      .ADDR_W(AW), .INST_W(IW), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .mem            (bus),
      .freeze_i       (freeze),
      .branch_taken_i (branch),
      .branch_addr_i  (baddr),
      .if_valid_o     (if_valid),
      .if_pc_o        (if_pc),
      .if_inst_o      (if_inst)
   );

   always #5 clk = ~clk;

   // Memory model: the word at an address is the address xor a fixed pattern.
   assign bus.mem_inst = bus.mem_addr ^ 32'hA5A5_0000;

   int            total = 0;
   int            bad   = 0;
   logic [63:0]   sb[$];
   logic [AW-1:0] m_pc   = '0;
   logic [AW-1:0] m_tgt  = '0;
   bit            m_disc = 1'b0;
   bit            m_pend = 1'b0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_pc   = 32'h0;
      m_tgt  = 32'h0;
      m_disc = 1'b0;
      m_pend = 1'b0;
   endtask

   // One clock: drive inputs, sample on the falling edge, advance the model.
   task automatic cycle(input bit ack, input bit frz, input bit br, input logic [AW-1:0] ba);
      logic exp_req;
      logic xfer;
      bus.mem_ack = ack;
      freeze      = frz;
      branch      = br;
      baddr       = ba;
      @(negedge clk);
      exp_req = m_disc || m_pend || (sb.size() < DEPTH);
      check("mem_req", 64'(bus.mem_req), 64'(exp_req));
      if (exp_req) check("mem_addr", 64'(bus.mem_addr), 64'(m_pc));
      check("if_valid", 64'(if_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) check("if_head", {if_pc, if_inst}, sb[0]);
      xfer = exp_req && ack;
      if (br) begin
         sb.delete();
         if (!exp_req || xfer) begin
            m_pc   = {ba[AW-1:2], 2'b00};
            m_disc = 1'b0;
         end else begin
            m_tgt  = {ba[AW-1:2], 2'b00};
            m_disc = 1'b1;
         end
      end else begin
         if (sb.size() != 0 && !frz) void'(sb.pop_front());
         if (m_disc) begin
            if (xfer) begin
               m_pc   = m_tgt;
               m_disc = 1'b0;
            end
         end else if (xfer) begin
            sb.push_back({m_pc + 32'd4, m_pc ^ 32'hA5A5_0000});
            m_pc = m_pc + 32'd4;
         end
      end
      m_pend = exp_req && !ack;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.mem_ack = 1'b0;
      #2;
      check("rst_req",   64'(bus.mem_req), 64'h0);
      check("rst_valid", 64'(if_valid),    64'h0);
      check("rst_pc",    64'(if_pc),       64'h0);
      check("rst_inst",  64'(if_inst),     64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // Streaming, one instruction per cycle.
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, '0);

      // Freeze: FIFO fills, requests stop, outputs hold; then resume.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, '0);

      // Branch with a full FIFO.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b1, 32'h40);
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("branch_first_pc", 64'(if_pc), 64'h44);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);

      // Branch during a slow request: old address held, acked word dropped.
      cycle(1'b0, 1'b0, 1'b1, 32'h80);
      cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("discard_target", 64'(bus.mem_addr), 64'h80);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);

      // Second branch while discarding replaces the saved target.
      cycle(1'b0, 1'b0, 1'b1, 32'h100);
      cycle(1'b0, 1'b0, 1'b1, 32'h200);
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("discard_overwrite", 64'(bus.mem_addr), 64'h200);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, '0);

      // Misaligned target and address wrap.
      cycle(1'b1, 1'b0, 1'b1, 32'h43);
      check("align", 64'(bus.mem_addr), 64'h40);
      cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, '0);
      check("wrap", 64'(bus.mem_addr), 64'h0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);

      // Random ack/freeze/branch mix.
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0, $urandom & 32'h0000_0FFF);

      // Reset while a request waits: outputs clear at once, stale ack ignored.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, 1'b0, '0);
      bus.mem_ack = 1'b0;
      freeze      = 1'b0;
      rst_n       = 1'b0;
      #1;
      check("mid_rst_req",   64'(bus.mem_req), 64'h0);
      check("mid_rst_valid", 64'(if_valid),    64'h0);
      check("mid_rst_inst",  64'(if_inst),     64'h0);
      bus.mem_ack = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_hold_req", 64'(bus.mem_req), 64'h0);
      rst_n = 1'b1;
      model_reset();
      check("restart_addr", 64'(bus.mem_addr), 64'h0);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
